// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle controller: FSM states, opcodes, ALU codes,
// and the instruction class classifier used in DECODE.
package ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      TRAP   = 3'd6
   } state_t;

   typedef enum logic [3:0] {
      CLS_R    = 4'd0,
      CLS_I    = 4'd1,
      CLS_LW   = 4'd2,
      CLS_SW   = 4'd3,
      CLS_BEQ  = 4'd4,
      CLS_JAL  = 4'd5,
      CLS_JALR = 4'd6,
      CLS_LUI  = 4'd7,
      CLS_ILL  = 4'd8
   } op_class_t;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0011;
   localparam logic [3:0] ALU_SLTU = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_XOR  = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;

   // Branches other than BEQ are not supported and fall into the illegal class.
   function automatic op_class_t classify(input logic [6:0] opcode, input logic [2:0] funct3);
      case (opcode)
         OP_R:    classify = CLS_R;
         OP_I:    classify = CLS_I;
         OP_LW:   classify = CLS_LW;
         OP_SW:   classify = CLS_SW;
         OP_BR:   classify = (funct3 == 3'b000) ? CLS_BEQ : CLS_ILL;
         OP_JAL:  classify = CLS_JAL;
         OP_JALR: classify = CLS_JALR;
         OP_LUI:  classify = CLS_LUI;
         default: classify = CLS_ILL;
      endcase
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational funct3/funct7-bit30 to aluctl mapping for R-type and I-ALU instructions.
module alu_decoder
   import ctrl_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       bit30,
   input  logic       is_rtype,
   output logic [3:0] aluctl
);

   // Bit 30 selects SUB only for R-type; immediates reuse that bit as data except for shifts.
   always_comb begin
      aluctl = ALU_ADD;
      case (funct3)
         3'b000:  aluctl = (is_rtype && bit30) ? ALU_SUB : ALU_ADD;
         3'b001:  aluctl = ALU_SLL;
         3'b010:  aluctl = ALU_SLT;
         3'b011:  aluctl = ALU_SLTU;
         3'b100:  aluctl = ALU_XOR;
         3'b101:  aluctl = bit30 ? ALU_SRA : ALU_SRL;
         3'b110:  aluctl = ALU_OR;
         3'b111:  aluctl = ALU_AND;
         default: aluctl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I-subset control FSM (Moore outputs decoded from registered state).
// Optional feature: define MULTICYCLE_CONTROL_TRAP_EN to send illegal instructions to TRAP.
module multicycle_control
   import ctrl_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         halt,
   input  logic [W-1:0] instruction,
   input  logic         zero,
   output logic         ir_write,
   output logic         pc_write,
   output logic         regwrite,
   output logic         memwrite,
   output logic         mem2reg,
   output logic         alusrc,
   output logic         branch,
   output logic         is_jal,
   output logic         is_jalr,
   output logic         is_lui,
   output logic [3:0]   aluctl,
   output logic         busy
);

   state_t     state_r, state_s;
   op_class_t  cls_r, dec_cls_s;
   logic [2:0] funct3_r;
   logic       bit30_r;
   logic [3:0] dec_aluctl_s;
   logic       unused_bits_s;

   // The branch outcome is resolved in the datapath, so zero never steers this FSM.
   assign unused_bits_s = ^{instruction[W-1:31], instruction[29:15], instruction[11:7], zero};
   assign dec_cls_s     = classify(instruction[6:0], instruction[14:12]);

   alu_decoder u_alu_decoder (
      .funct3   (funct3_r),
      .bit30    (bit30_r),
      .is_rtype (cls_r == CLS_R),
      .aluctl   (dec_aluctl_s)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Instruction fields captured once in DECODE and held for the rest of the instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cls_r    <= CLS_ILL;
         funct3_r <= 3'b000;
         bit30_r  <= 1'b0;
      end else if (state_r == DECODE) begin
         cls_r    <= dec_cls_s;
         funct3_r <= instruction[14:12];
         bit30_r  <= instruction[30];
      end else begin
         cls_r    <= cls_r;
         funct3_r <= funct3_r;
         bit30_r  <= bit30_r;
      end
   end

   // Next-state logic; halt matters only in IDLE and in the final pc_write cycle.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:   state_s = halt ? IDLE : FETCH;
         FETCH:  state_s = DECODE;
         DECODE: begin
`ifdef MULTICYCLE_CONTROL_TRAP_EN
            state_s = (dec_cls_s == CLS_ILL) ? TRAP : EXEC;
`else
            state_s = EXEC;
`endif
         end
         EXEC: begin
            case (cls_r)
               CLS_R, CLS_I:   state_s = WB;
               CLS_LW, CLS_SW: state_s = MEM;
               default:        state_s = halt ? IDLE : FETCH;
            endcase
         end
         MEM:    state_s = (cls_r == CLS_LW) ? WB : (halt ? IDLE : FETCH);
         WB:     state_s = halt ? IDLE : FETCH;
         TRAP:   state_s = TRAP;
         default: state_s = IDLE;
      endcase
   end

   // Output decode from registered state and captured fields.
   always_comb begin
      ir_write = 1'b0;
      pc_write = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
      mem2reg  = 1'b0;
      alusrc   = 1'b0;
      branch   = 1'b0;
      is_jal   = 1'b0;
      is_jalr  = 1'b0;
      is_lui   = 1'b0;
      aluctl   = 4'b0000;
      busy     = (state_r != IDLE);
      case (state_r)
         FETCH: ir_write = 1'b1;
         EXEC: begin
            case (cls_r)
               CLS_R: aluctl = dec_aluctl_s;
               CLS_I: begin
                  aluctl = dec_aluctl_s;
                  alusrc = 1'b1;
               end
               CLS_LW, CLS_SW: begin
                  aluctl = ALU_ADD;
                  alusrc = 1'b1;
               end
               CLS_BEQ: begin
                  aluctl   = ALU_SUB;
                  branch   = 1'b1;
                  pc_write = 1'b1;
               end
               CLS_JAL: begin
                  is_jal   = 1'b1;
                  regwrite = 1'b1;
                  pc_write = 1'b1;
               end
               CLS_JALR: begin
                  is_jalr  = 1'b1;
                  regwrite = 1'b1;
                  pc_write = 1'b1;
               end
               CLS_LUI: begin
                  is_lui   = 1'b1;
                  regwrite = 1'b1;
                  pc_write = 1'b1;
               end
               default: pc_write = 1'b1;
            endcase
         end
         MEM: begin
            if (cls_r == CLS_LW) begin
               mem2reg = 1'b1;
            end else begin
               memwrite = 1'b1;
               pc_write = 1'b1;
            end
         end
         WB: begin
            mem2reg  = (cls_r == CLS_LW);
            regwrite = 1'b1;
            pc_write = 1'b1;
         end
         default: busy = (state_r != IDLE);
      endcase
   end

endmodule
